// File: rtl/nios_key_pio.sv
// nios_key_pio: Avalon-MM slave input PIO for push-buttons and switches.
//   Each input bit goes through a 2-flop synchronizer. The block then
//   detects edges on the synchronized value and latches them in a
//   per-bit edge-capture register. A level interrupt is raised for every
//   captured edge whose mask bit is set.
//
// Ports
//   clk, reset_n         system clock; asynchronous active-low reset
//   address[1:0]         word select: 0 DATA, 1 reserved, 2 IRQ_MASK,
//                        3 EDGE_CAPTURE (write 1 to clear)
//   chipselect, write_n  a write happens on a clk edge with cs=1, write_n=0
//   writedata[31:0]      write data
//   in_port[WIDTH-1:0]   asynchronous external inputs
//   readdata[31:0]       combinational read data, zero-extended above WIDTH
//   irq                  |(edge_capture & irq_mask)
//
// Parameters
//   WIDTH      number of input bits (1..32)
//   EDGE_TYPE  0 rising, 1 falling, 2 any

// Per-bit lane: synchronizer, edge detector and capture flop.
module nios_key_pio_bit #(
    parameter int EDGE_TYPE = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    input  logic clr,
    output logic data,
    output logic cap
);

    logic sync1, sync2, prev, detect;

    always_comb begin
        case (EDGE_TYPE)
            1:       detect = ~sync2 & prev;
            2:       detect = sync2 ^ prev;
            default: detect = sync2 & ~prev;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            cap   <= 1'b0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
            prev  <= sync2;
            // A new edge takes priority over a clear in the same cycle,
            // so firmware never loses an edge it has not seen yet.
            if (detect)
                cap <= 1'b1;
            else if (clr)
                cap <= 1'b0;
        end
    end

    assign data = sync2;

endmodule

module nios_key_pio #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] data, cap, mask, clr;
    logic             unused_wd;

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Upper writedata bits carry no register state when WIDTH < 32.
    assign unused_wd = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nios_key_pio_bit #(.EDGE_TYPE(EDGE_TYPE)) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[i]),
            .clr     (clr[i]),
            .data    (data[i]),
            .cap     (cap[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mask <= '0;
        else if (wr && address == 2'd2)
            mask <= writedata[WIDTH-1:0];
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = data;
            2'd2:    readdata[WIDTH-1:0] = mask;
            2'd3:    readdata[WIDTH-1:0] = cap;
            default: readdata = '0;
        endcase
    end

    assign irq = |(cap & mask);

endmodule

// File: tb/tb_nios_key_pio.sv
// Directed bench for nios_key_pio. Three instances share the bus (one
// per EDGE_TYPE). Each instance has its own in_port, readdata and irq.
module tb_nios_key_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in0, in1, in2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_key_pio #(.WIDTH(8), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
    nios_key_pio #(.WIDTH(8), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
    nios_key_pio #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clk edge and settle just after it.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd_chk(input int which, input logic [1:0] a, input logic [31:0] exp,
                          input string tag);
        logic [31:0] obs;
        address = a;
        #1;
        case (which)
            1:       obs = rd1;
            2:       obs = rd2;
            default: obs = rd0;
        endcase
        chk(tag, obs, exp);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in0 = '0; in1 = '0; in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        // 1: reset state
        chk("rst_irq0", {31'b0, irq0}, 32'd0);
        chk("rst_irq1", {31'b0, irq1}, 32'd0);
        chk("rst_irq2", {31'b0, irq2}, 32'd0);
        reset_n = 1'b1;
        tick();
        rd_chk(0, 2'd0, 32'h0, "rst_data");
        rd_chk(0, 2'd1, 32'h0, "rst_resv");
        rd_chk(0, 2'd2, 32'h0, "rst_mask");
        rd_chk(0, 2'd3, 32'h0, "rst_cap");
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFF);
        rd_chk(0, 2'd0, 32'h0, "ro_data");
        rd_chk(0, 2'd1, 32'h0, "ro_resv");
        rd_chk(0, 2'd2, 32'h0, "ro_mask");
        rd_chk(0, 2'd3, 32'h0, "ro_cap");

        // 2: rising edge latency and W1C
        wr(2'd2, 32'h01);
        in0 = 8'h01;
        tick(2);
        rd_chk(0, 2'd0, 32'h01, "lat_data_e2");
        rd_chk(0, 2'd3, 32'h00, "lat_cap_e2");
        chk("lat_irq_e2", {31'b0, irq0}, 32'd0);
        tick();
        rd_chk(0, 2'd3, 32'h01, "lat_cap_e3");
        chk("lat_irq_e3", {31'b0, irq0}, 32'd1);
        wr(2'd3, 32'h01);
        rd_chk(0, 2'd3, 32'h00, "w1c_cap");
        chk("w1c_irq", {31'b0, irq0}, 32'd0);

        // 3: masking
        wr(2'd2, 32'h00);
        in0 = 8'h00;
        tick(3);
        in0 = 8'h0A;
        tick(3);
        rd_chk(0, 2'd3, 32'h0A, "msk_cap");
        chk("msk_irq_off", {31'b0, irq0}, 32'd0);
        wr(2'd2, 32'h02);
        chk("msk_irq_on", {31'b0, irq0}, 32'd1);
        rd_chk(0, 2'd3, 32'h0A, "msk_cap_kept");
        wr(2'd3, 32'h02);
        chk("msk_irq_clr", {31'b0, irq0}, 32'd0);
        rd_chk(0, 2'd3, 32'h08, "msk_cap_clr");

        // 4: detect and W1C on bit 2 in the same cycle
        in0 = 8'h0E;
        tick(2);
        wr(2'd3, 32'h04);
        rd_chk(0, 2'd3, 32'h0C, "setwins");
        wr(2'd3, 32'h04);
        rd_chk(0, 2'd3, 32'h08, "setwins_clr");

        // 5: falling-edge instance
        in1 = 8'hFF;
        tick(3);
        rd_chk(1, 2'd3, 32'h00, "fall_rise_ign");
        in1 = 8'hF0;
        tick(3);
        rd_chk(1, 2'd3, 32'h0F, "fall_cap");
        chk("fall_irq", {31'b0, irq1}, 32'd1);
        // any-edge instance: up, clear, down
        in2 = 8'h80;
        tick(3);
        rd_chk(2, 2'd3, 32'h80, "any_up");
        wr(2'd3, 32'h80);
        rd_chk(2, 2'd3, 32'h00, "any_clr");
        in2 = 8'h00;
        tick(3);
        rd_chk(2, 2'd3, 32'h80, "any_down");

        // 6: async reset mid-operation, then post-reset edge
        wr(2'd2, 32'h08);
        chk("pre_rst_irq", {31'b0, irq0}, 32'd1);
        in0 = 8'h01;
        reset_n = 1'b0;
        #1;
        chk("async_irq", {31'b0, irq0}, 32'd0);
        rd_chk(0, 2'd2, 32'h00, "async_mask");
        rd_chk(0, 2'd3, 32'h00, "async_cap");
        tick();
        reset_n = 1'b1;
        tick(2);
        rd_chk(0, 2'd3, 32'h00, "post_rst_e2");
        tick();
        rd_chk(0, 2'd3, 32'h01, "post_rst_e3");
        chk("post_rst_irq", {31'b0, irq0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_key_pio.md
Name: nios_key_pio

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the team's output LED PIO.
- Samples an external input bus (push-buttons/switches) through a 2-flop synchronizer and presents it to the Nios II data master.
- Latches selected edges in a per-bit edge-capture register.
- Raises a level-sensitive interrupt for each unmasked captured edge.

Parameters:
- WIDTH, 8, width of in_port, irq_mask and edge_capture (1..32).
- EDGE_TYPE, 0, edge detected: 0 rising, 1 falling, 2 any.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register word select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  read data, combinational from address, zero-extended above WIDTH.
- irq  output  1  level interrupt to the CPU.

Behaviour:
- Reset and clocking:
  - Reset is reset_n, asynchronous, active-low; clock is clk.
  - On reset, sync1, sync2, prev, irq_mask and edge_capture all go to 0; irq=0.
  - readdata then reflects the zeroed registers.
- Register map (word addresses):
  - 0 DATA (RO): sync2. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK (RW): a write loads writedata[WIDTH-1:0]; reads return the mask.
  - 3 EDGE_CAPTURE (R/W1C): reads return the capture bits; a write clears each bit whose writedata bit is 1.
- Write qualification:
  - A write occurs on the rising clk edge where chipselect=1 and write_n=0.
  - Zero wait states; no read side effects; readdata is valid in the same cycle as address.
- Synchronizer:
  - Each edge: sync1<=in_port, sync2<=sync1, prev<=sync2.
- Edge detect (combinational), per bit:
  - rising: sync2 & ~prev
  - falling: ~sync2 & prev
  - any: sync2 ^ prev
- Capture:
  - edge_capture[i] <= 1 on an edge where detect[i]=1.
  - Otherwise it is cleared by a W1C write, else it holds.
- Simultaneous detect and W1C on the same bit in the same cycle: set wins, so the bit stays 1.
- Latency:
  - in_port transition before clk edge 1 gives sync1 after edge 1 and DATA readable after edge 2.
  - edge_capture is set after edge 3.
  - irq = |(edge_capture & irq_mask), combinational from registers, so irq is high immediately after edge 3 when the bit is unmasked.
- Masking:
  - Writing the mask never alters edge_capture.
  - Unmasking an already-captured bit asserts irq in the cycle after the mask write edge.
  - irq stays asserted until every unmasked captured bit is cleared.
- Pulse filtering:
  - A pulse shorter than one clk period may be missed; this is accepted.
  - A pulse of at least 2 periods is guaranteed to be captured.
- Post-reset edge:
  - prev resets to 0. If in_port is held high through reset release, a rising edge is captured 3 cycles after release (EDGE_TYPE 0 or 2).
  - Firmware clears EDGE_CAPTURE at init.
- Reset mid-operation clears pending captures and deasserts irq immediately (asynchronously).

Test Plan:
1. Reset, read all addresses -> readdata=0 at addresses 0..3; irq=0. Write 0xFF to address 0 -> DATA still follows in_port; irq_mask and edge_capture unchanged.
2. EDGE_TYPE=0, mask=0x01, in_port 0x00->0x01 before edge 1 -> DATA=0x01 after edge 2; EDGE_CAPTURE=0x01 and irq=1 after edge 3. Write 0x01 to address 3 -> capture=0, irq=0 the next cycle.
3. mask=0x00, in_port 0x00->0x0A -> EDGE_CAPTURE=0x0A, irq stays 0. Write mask 0x02 -> irq=1. Write 0x02 to address 3 -> irq=0, EDGE_CAPTURE=0x08.
4. Bit 2 edge detected in the same cycle as a W1C write of 0x04 to address 3 -> bit 2 remains 1 (set wins).
5. EDGE_TYPE=1: in_port 0xFF->0xF0 -> EDGE_CAPTURE=0x0F. EDGE_TYPE=2: toggle bit 7 up then down, clearing between the two edges -> captured twice.
6. irq=1, pulse reset_n low for 1 cycle -> irq, mask and capture go to 0 at once. in_port held at 0x01 through release -> EDGE_CAPTURE=0x01 three cycles after release.
